// File: rtl/axis_fifo_packer.sv
// Packs IN_WIDTH AXI-Stream samples into DATA_WIDTH FIFO words and pads each
// frame to a whole number of BURST_LEN-word bursts.
module axis_fifo_packer #(
  parameter int unsigned         IN_WIDTH   = 8,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         BURST_LEN  = 8,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  m00_axi_aresetn,
  input  logic [IN_WIDTH-1:0]   s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_full,
  input  logic                  fifo_prog_full,
  output logic                  frame_done,
  output logic [15:0]           frame_words
);

  localparam int unsigned RATIO = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [DATA_WIDTH-1:0] PAD_WORD = {RATIO{PAD_VALUE}};

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_PAD, ST_DONE} state_t;

  state_t                state, state_nx;
  logic [LW-1:0]         lane, lane_nx;
  logic [DATA_WIDTH-1:0] pack_buf, pack_nx;
  logic [DATA_WIDTH-1:0] wbuf, wbuf_nx;
  logic [DATA_WIDTH-1:0] merged;
  logic                  wpend, wpend_nx;
  logic [BW-1:0]         burst_cnt, burst_inc, burst_nx;
  logic [15:0]           words_nx;
  logic                  clr_words, clr_nx;
  logic                  accept, last_lane, slot_free;

  assign fifo_wren   = wpend & ~fifo_full;
  assign fifo_wrdata = wbuf;
  assign frame_done  = (state == ST_DONE);
  assign s_tready    = ~m00_axi_aresetn & (state == ST_RUN) & ~fifo_prog_full
                       & (~wpend | ~fifo_full);
  assign accept      = s_tvalid & s_tready;
  assign last_lane   = (lane == LW'(RATIO - 1));
  assign slot_free   = ~wpend | fifo_wren;
  assign burst_inc   = (burst_cnt == BW'(BURST_LEN - 1)) ? '0 : burst_cnt + 1'b1;
  assign burst_nx    = fifo_wren ? burst_inc : burst_cnt;

  // Current partial word with the incoming sample dropped into its lane.
  always_comb begin
    merged = pack_buf;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (lane == LW'(i)) merged[i*IN_WIDTH +: IN_WIDTH] = s_tdata;
    end
  end

  always_comb begin
    state_nx = state;
    lane_nx  = lane;
    pack_nx  = pack_buf;
    wbuf_nx  = wbuf;
    wpend_nx = wpend & ~fifo_wren;
    clr_nx   = clr_words;
    words_nx = frame_words;

    if (fifo_wren) begin
      if (clr_words) begin
        words_nx = 16'd1;
        clr_nx   = 1'b0;
      end else begin
        words_nx = frame_words + 16'd1;
      end
    end

    case (state)
      ST_RUN: begin
        if (accept) begin
          if (last_lane) begin
            wbuf_nx  = merged;
            wpend_nx = 1'b1;
            pack_nx  = PAD_WORD;
            lane_nx  = '0;
            // PAD settles the aligned/unaligned choice once this word lands.
            if (s_tlast) state_nx = ST_PAD;
          end else begin
            pack_nx = merged;
            lane_nx = lane + 1'b1;
            if (s_tlast) state_nx = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          wbuf_nx  = pack_buf;
          wpend_nx = 1'b1;
          pack_nx  = PAD_WORD;
          lane_nx  = '0;
          state_nx = ST_PAD;
        end
      end
      ST_PAD: begin
        if (slot_free) begin
          if (burst_nx != '0) begin
            wbuf_nx  = PAD_WORD;
            wpend_nx = 1'b1;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        clr_nx   = 1'b1;
        state_nx = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge m00_axi_aresetn) begin
    if (m00_axi_aresetn) begin
      state       <= ST_RUN;
      lane        <= '0;
      pack_buf    <= PAD_WORD;
      wbuf        <= '0;
      wpend       <= 1'b0;
      burst_cnt   <= '0;
      frame_words <= '0;
      clr_words   <= 1'b0;
    end else begin
      state       <= state_nx;
      lane        <= lane_nx;
      pack_buf    <= pack_nx;
      wbuf        <= wbuf_nx;
      wpend       <= wpend_nx;
      burst_cnt   <= burst_nx;
      frame_words <= words_nx;
      clr_words   <= clr_nx;
    end
  end

endmodule

// File: tb/tb_axis_fifo_packer.sv
// Scoreboard bench for axis_fifo_packer: stimulus pushes expected FIFO words and
// frame lengths, a negedge monitor pops and compares.
module tb_axis_fifo_packer;

  logic        clk = 1'b0;
  logic        m00_axi_aresetn;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic        fifo_wren;
  logic [31:0] fifo_wrdata;
  logic        fifo_full, fifo_prog_full;
  logic        frame_done;
  logic [15:0] frame_words;

  always #5 clk = ~clk;

  axis_fifo_packer #(
    .IN_WIDTH(8), .DATA_WIDTH(32), .BURST_LEN(8), .PAD_VALUE(8'h00)
  ) dut (
    .clk(clk), .m00_axi_aresetn(m00_axi_aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
    .frame_done(frame_done), .frame_words(frame_words)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          done_q[$];
  int          wr_since_done = 0;
  int          gap = 1000;
  int          done_seen = 0;

  always @(negedge clk) begin : monitor
    logic [31:0] ew;
    int          ef;
    if (m00_axi_aresetn) begin
      wr_since_done = 0;
      gap = 1000;
    end else begin
      if (fifo_full) begin
        checks++;
        if (fifo_wren) begin
          errors++;
          $display("FAIL wren_while_full got 1 want 0 at %0t", $time);
        end
      end
      if (fifo_prog_full) begin
        checks++;
        if (s_tready) begin
          errors++;
          $display("FAIL tready_while_prog_full got 1 want 0 at %0t", $time);
        end
      end
      if (frame_done) begin
        checks++;
        if (gap != 0) begin
          errors++;
          $display("FAIL done_latency got %0d idle cycles want 0 at %0t", gap, $time);
        end
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at %0t", $time);
        end else begin
          ef = done_q.pop_front();
          if (frame_words !== 16'(ef)) begin
            errors++;
            $display("FAIL frame_words got %0d want %0d at %0t", frame_words, ef, $time);
          end
          checks++;
          if (wr_since_done != ef) begin
            errors++;
            $display("FAIL frame_write_count got %0d want %0d at %0t", wr_since_done, ef, $time);
          end
        end
        done_seen++;
        wr_since_done = 0;
      end
      if (fifo_wren) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got %h at %0t", fifo_wrdata, $time);
        end else begin
          ew = exp_q.pop_front();
          if (fifo_wrdata !== ew) begin
            errors++;
            $display("FAIL wrdata got %h want %h at %0t", fifo_wrdata, ew, $time);
          end
        end
        wr_since_done++;
        gap = 0;
      end else if (gap < 1000) begin
        gap++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int   t;
    logic rdy;
    t = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    do begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 300);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout sample %h not taken in %0d cycles", d, t);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int first, input int n);
    for (int i = 0; i < n; i++) send(8'(first + i), (i == n - 1));
  endtask

  // Samples first..first+n-1, little-endian lanes, zero fill, burst-aligned pad.
  task automatic expect_seq(input int first, input int n);
    int          nw;
    logic [31:0] w;
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int l = 0; l < 4; l++)
        if (k * 4 + l < n) w[l*8 +: 8] = 8'(first + k * 4 + l);
      exp_q.push_back(w);
    end
    while (nw % 8 != 0) begin
      exp_q.push_back(32'h0);
      nw++;
    end
    done_q.push_back(nw);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_seen < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_seen < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d frames want %0d", done_seen, target);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"}, {31'b0, s_tready}, 32'h0);
    chk({tag, "_wren"}, {31'b0, fifo_wren}, 32'h0);
    chk({tag, "_wrdata"}, fifo_wrdata, 32'h0);
    chk({tag, "_done"}, {31'b0, frame_done}, 32'h0);
    chk({tag, "_words"}, {16'b0, frame_words}, 32'h0);
  endtask

  initial begin
    m00_axi_aresetn = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    fifo_full = 1'b0; fifo_prog_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    m00_axi_aresetn = 1'b0;
    @(posedge clk);
    #1;

    // T1: aligned frame, no pad
    expect_seq(8'h01, 32);
    send_frame(8'h01, 32);
    wait_done(1);

    // T2: 10 samples -> 3 data words + 5 pad, hand-computed
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h00000A09);
    repeat (5) exp_q.push_back(32'h00000000);
    done_q.push_back(8);
    send_frame(8'h01, 10);
    wait_done(2);

    // T3: fifo_full held 20 cycles mid-frame
    expect_seq(8'h30, 24);
    fork
      send_frame(8'h30, 24);
      begin
        repeat (6) @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("tready_during_full", {31'b0, s_tready}, 32'h0);
        @(posedge clk);
        #1 fifo_full = 1'b0;
      end
    join
    wait_done(3);

    // T4: prog_full toggling every 3 cycles over 64 samples
    expect_seq(8'h40, 64);
    fork
      send_frame(8'h40, 64);
      begin
        for (int k = 0; k < 24; k++) begin
          repeat (3) @(posedge clk);
          #1 fifo_prog_full = ~fifo_prog_full;
        end
        fifo_prog_full = 1'b0;
      end
    join
    wait_done(4);

    // T5: reset after 6 samples, then a 4-sample frame restarts at lane 0
    exp_q.push_back(32'h04030201);
    for (int i = 0; i < 6; i++) send(8'(i + 1), 1'b0);
    m00_axi_aresetn = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 m00_axi_aresetn = 1'b0;
    @(posedge clk);
    #1;
    expect_seq(8'h11, 4);
    send_frame(8'h11, 4);
    wait_done(5);

    // T6: back-to-back frames
    expect_seq(8'hA0, 5);
    expect_seq(8'hB0, 8);
    send_frame(8'hA0, 5);
    send_frame(8'hB0, 8);
    wait_done(7);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
